mem_req_scheduler: RTL and testbench
====================================

// Module: mem_req_scheduler
// PURPOSE
//  Shares the single cache_adapter cacheline port among three requesters: dcache, icache and a
//  next-line instruction prefetcher. Allows one transaction in flight at a time.
//  Base priority: dcache > icache > prefetch. Per-requester aging counters guarantee starvation freedom.
//  Sits between the L1 caches/prefetcher and cache_adapter. It replaces the 2-way arbiter path
//  when the prefetcher is enabled.
// PARAMETERS
//  STARVE_LIMIT  4   lost arbitration rounds after which a pending requester is promoted
//  CNT_W         3   aging counter width; must satisfy 2**CNT_W > STARVE_LIMIT
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous active-high reset
//  dc_addr      in   32   dcache line address, bits [4:0] ignored (forced 0 downstream)
//  dc_read      in   1    dcache read request, held until dc_resp
//  dc_write     in   1    dcache writeback request, held until dc_resp
//  dc_wdata     in   256  dcache writeback line
//  dc_rdata     out  256  read line returned to dcache
//  dc_resp      out  1    1-cycle completion pulse to dcache
//  ic_addr      in   32   icache line address
//  ic_read      in   1    icache read request, held until ic_resp
//  ic_rdata     out  256  read line returned to icache
//  ic_resp      out  1    completion pulse to icache
//  pf_addr      in   32   prefetch line address
//  pf_read      in   1    prefetch read request (may drop before grant only)
//  pf_rdata     out  256  read line returned to prefetcher
//  pf_resp      out  1    completion pulse to prefetcher
//  dfp_addr     out  32   address to cache_adapter, bits [4:0]=0
//  dfp_read     out  1    read to adapter, held while BUSY on a read
//  dfp_write    out  1    write to adapter, held while BUSY on a write
//  dfp_wdata    out  256  write line to adapter
//  dfp_rdata    in   256  read line from adapter
//  dfp_resp     in   1    adapter completion pulse
//  grant_id     out  2    debug: 0 none, 1 dc, 2 ic, 3 pf (registered owner)
// BEHAVIOUR
//  Reset: FSM=IDLE, grant_id=0, all aging counters=0.
//  Reset: all *_resp=0, dfp_read=dfp_write=0, dfp_addr=0, dfp_wdata=0.
//  A reset mid-transaction abandons the transaction; no resp is emitted afterwards.
//  FSM IDLE:
//   - Pending set P = {dc if dc_read|dc_write, ic if ic_read, pf if pf_read}.
//   - If P is non-empty, latch the winner's id/addr/op/wdata and go to BUSY (1-cycle arbitration latency).
//   - Winner: among P members with age>=STARVE_LIMIT, pick by base priority. Otherwise pick the base-priority winner of P.
//   - Aging: each non-winning member of P increments its age, saturating at 2**CNT_W-1. The winner's age clears.
//   - Non-pending requesters hold their age.
//  FSM BUSY:
//   - dfp_* driven from the latched registers only, so they stay stable even if requester inputs change.
//   - On dfp_resp: the owner's *_resp=1 in the same cycle (combinational).
//   - On dfp_resp: the owner's *_rdata=dfp_rdata, valid only while *_resp=1. Non-owners see resp=0.
//   - On dfp_resp: return to IDLE, grant_id->0.
//   - A new grant occurs no earlier than the cycle after dfp_resp (one bubble cycle). Back-to-back throughput is resp-to-resp + 2.
//  dc_read&dc_write both high: treated as write; the read is ignored.
//  pf_read dropping while not granted: removes pf from P and holds its age. After grant, pf input changes are ignored.
//  Requester issuing again the cycle after its resp: legal; arbitrated normally.
//  dfp_resp while IDLE: ignored; no *_resp is generated (sim assertion fires).
//  Address: dfp_addr = {latched_addr[31:5], 5'b0}.
//  Aging arithmetic is unsigned. At STARVE_LIMIT=4, icache under continuous dcache pressure gets at most 4 consecutive losses.
// TESTING
//  1 Reset: rst=1 for 2 cycles -> all resp=0, dfp_read=dfp_write=0, grant_id=0.
//  2 Single ic: ic_read, ic_addr=0x1000_0044 -> next cycle dfp_read=1, dfp_addr=0x1000_0040, grant_id=2.
//    Adapter resp with rdata=X -> ic_resp=1, ic_rdata=X.
//  3 Simultaneous dc write (0x2000) + ic read (0x3000) -> dc granted first with dfp_write=1, dfp_wdata=dc_wdata.
//    ic granted the cycle after dc_resp + 1.
//  4 Starvation: dc_read held continuously and re-issued after each resp, ic_read held.
//    -> ic granted on the 5th arbitration (after 4 dc grants), then dc resumes.
//  5 Prefetch drop: pf_read for 1 cycle while BUSY on dc, then deasserted -> pf never granted, pf_resp never asserted.
//  6 Mid-flight reset: rst asserted while BUSY on ic, dfp_resp arrives after reset -> ic_resp stays 0, FSM IDLE.

Source files
------------

// File: rtl/mem_req_scheduler_if.sv
// Bundle of the three requester ports (dcache, icache, prefetcher) and the
// downstream cacheline port to cache_adapter.
//
// Handshake: each requester raises its read/write level and holds it until
// its 1-cycle *_resp pulse (the prefetcher may drop its read before grant).
// The scheduler holds dfp_read/dfp_write with stable addr/wdata until the
// adapter pulses dfp_resp for one cycle; dfp_rdata is valid in that cycle.
interface mem_req_scheduler_if;
    logic [31:0]  dc_addr;
    logic         dc_read;
    logic         dc_write;
    logic [255:0] dc_wdata;
    logic [255:0] dc_rdata;
    logic         dc_resp;

    logic [31:0]  ic_addr;
    logic         ic_read;
    logic [255:0] ic_rdata;
    logic         ic_resp;

    logic [31:0]  pf_addr;
    logic         pf_read;
    logic [255:0] pf_rdata;
    logic         pf_resp;

    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;

    // Scheduler side
    modport slave (
        input  dc_addr, dc_read, dc_write, dc_wdata,
        output dc_rdata, dc_resp,
        input  ic_addr, ic_read,
        output ic_rdata, ic_resp,
        input  pf_addr, pf_read,
        output pf_rdata, pf_resp,
        output dfp_addr, dfp_read, dfp_write, dfp_wdata,
        input  dfp_rdata, dfp_resp
    );

    // Requester/adapter side (drives the scheduler)
    modport master (
        output dc_addr, dc_read, dc_write, dc_wdata,
        input  dc_rdata, dc_resp,
        output ic_addr, ic_read,
        input  ic_rdata, ic_resp,
        output pf_addr, pf_read,
        input  pf_rdata, pf_resp,
        input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
        output dfp_rdata, dfp_resp
    );
endinterface

// File: rtl/mem_req_scheduler.sv
// Three-way scheduler for the single cache_adapter cacheline port.
// One transaction in flight; base priority dc > ic > pf, with per-requester
// aging counters promoting any requester that has lost STARVE_LIMIT rounds.
module mem_req_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_req_scheduler_if.slave    bus,
    output logic [1:0]            grant_id
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] ID_NONE = 2'd0;
    localparam logic [1:0] ID_DC   = 2'd1;
    localparam logic [1:0] ID_IC   = 2'd2;
    localparam logic [1:0] ID_PF   = 2'd3;

    localparam logic [CNT_W-1:0] AGE_LIM = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] AGE_MAX = '1;

    state_t             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [31:0]        addr_q, addr_d;
    logic [255:0]       wdata_q, wdata_d;
    logic               write_q, write_d;
    logic [CNT_W-1:0]   dc_age_q, dc_age_d;
    logic [CNT_W-1:0]   ic_age_q, ic_age_d;
    logic [CNT_W-1:0]   pf_age_q, pf_age_d;

    logic               dc_p, ic_p, pf_p;
    logic               dc_s, ic_s, pf_s;
    logic [1:0]         win;
    logic               busy;
    logic               resp_fire;

    // Losers count up (saturating), the winner clears, idle requesters hold.
    function automatic logic [CNT_W-1:0] age_next(input logic pend, input logic won,
                                                  input logic [CNT_W-1:0] age);
        logic [CNT_W-1:0] r;
        r = age;
        if (pend) begin
            if (won) begin
                r = '0;
            end else if (age != AGE_MAX) begin
                r = age + CNT_W'(1);
            end
        end
        return r;
    endfunction

    // Pending set and winner selection: starving requesters first, then base priority.
    always_comb begin
        dc_p = bus.dc_read | bus.dc_write;
        ic_p = bus.ic_read;
        pf_p = bus.pf_read;
        dc_s = dc_p && (dc_age_q >= AGE_LIM);
        ic_s = ic_p && (ic_age_q >= AGE_LIM);
        pf_s = pf_p && (pf_age_q >= AGE_LIM);
        win  = ID_NONE;
        if (dc_s || ic_s || pf_s) begin
            if (dc_s)      win = ID_DC;
            else if (ic_s) win = ID_IC;
            else           win = ID_PF;
        end else begin
            if (dc_p)      win = ID_DC;
            else if (ic_p) win = ID_IC;
            else if (pf_p) win = ID_PF;
        end
    end

    // Next-state logic: arbitrate and latch in IDLE, wait for adapter in BUSY.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        dc_age_d = dc_age_q;
        ic_age_d = ic_age_q;
        pf_age_d = pf_age_q;
        case (state_q)
            IDLE: begin
                if (win != ID_NONE) begin
                    state_d = BUSY;
                    owner_d = win;
                    case (win)
                        ID_DC: begin
                            addr_d  = bus.dc_addr;
                            wdata_d = bus.dc_wdata;
                            // A simultaneous read is dropped; the write wins.
                            write_d = bus.dc_write;
                        end
                        ID_IC: begin
                            addr_d  = bus.ic_addr;
                            wdata_d = '0;
                            write_d = 1'b0;
                        end
                        default: begin
                            addr_d  = bus.pf_addr;
                            wdata_d = '0;
                            write_d = 1'b0;
                        end
                    endcase
                end
                dc_age_d = age_next(dc_p, win == ID_DC, dc_age_q);
                ic_age_d = age_next(ic_p, win == ID_IC, ic_age_q);
                pf_age_d = age_next(pf_p, win == ID_PF, pf_age_q);
            end
            BUSY: begin
                if (bus.dfp_resp) begin
                    state_d = IDLE;
                    owner_d = ID_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = ID_NONE;
            end
        endcase
    end

    // State and latched-transaction registers; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= ID_NONE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            dc_age_q <= '0;
            ic_age_q <= '0;
            pf_age_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            dc_age_q <= dc_age_d;
            ic_age_q <= ic_age_d;
            pf_age_q <= pf_age_d;
        end
    end

    assign busy      = (state_q == BUSY);
    assign resp_fire = busy & bus.dfp_resp;

    // Downstream port comes only from latched state, so it is immune to requester changes.
    assign bus.dfp_read  = busy & ~write_q;
    assign bus.dfp_write = busy & write_q;
    assign bus.dfp_addr  = busy ? (addr_q & 32'hFFFF_FFE0) : 32'h0;
    assign bus.dfp_wdata = (busy & write_q) ? wdata_q : '0;

    // Completion is routed combinationally to the owner only.
    assign bus.dc_resp  = resp_fire && (owner_q == ID_DC);
    assign bus.ic_resp  = resp_fire && (owner_q == ID_IC);
    assign bus.pf_resp  = resp_fire && (owner_q == ID_PF);
    assign bus.dc_rdata = bus.dc_resp ? bus.dfp_rdata : '0;
    assign bus.ic_rdata = bus.ic_resp ? bus.dfp_rdata : '0;
    assign bus.pf_rdata = bus.pf_resp ? bus.dfp_rdata : '0;

    assign grant_id = owner_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler: a table of single-transaction vectors
// plus hand-written sequences for bubble timing, starvation, prefetch drop
// and mid-flight reset.
module tb_mem_req_scheduler;

    logic       clk;
    logic       rst;
    logic [1:0] grant_id;
    int         n_chk;
    int         n_fail;

    mem_req_scheduler_if bus();

    mem_req_scheduler #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dc_rd;
        logic        dc_wr;
        logic        ic_rd;
        logic        pf_rd;
        logic [31:0] dc_a;
        logic [31:0] ic_a;
        logic [31:0] pf_a;
        logic [1:0]  exp_gid;
        logic [31:0] exp_addr;
        logic        exp_wr;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dc_addr   = '0;
        bus.dc_read   = 1'b0;
        bus.dc_write  = 1'b0;
        bus.dc_wdata  = '0;
        bus.ic_addr   = '0;
        bus.ic_read   = 1'b0;
        bus.pf_addr   = '0;
        bus.pf_read   = 1'b0;
        bus.dfp_rdata = '0;
        bus.dfp_resp  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [2:0] resp_onehot(input logic [1:0] gid);
        logic [2:0] r;
        case (gid)
            2'd1:    r = 3'b100;
            2'd2:    r = 3'b010;
            2'd3:    r = 3'b001;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [255:0] owner_rdata(input logic [1:0] gid);
        logic [255:0] r;
        case (gid)
            2'd1:    r = bus.dc_rdata;
            2'd2:    r = bus.ic_rdata;
            default: r = bus.pf_rdata;
        endcase
        return r;
    endfunction

    initial begin
        logic [255:0] wd;
        logic [255:0] rd;
        logic [1:0]   star_exp [6];
        n_chk  = 0;
        n_fail = 0;

        //          dc_rd dc_wr ic_rd pf_rd dc_a          ic_a          pf_a          gid   exp_addr      wr
        vt[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h1000_0044, 32'h0,        2'd2, 32'h1000_0040, 1'b0};
        vt[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, 32'h0,        2'd1, 32'h0000_2000, 1'b1};
        vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_3000, 32'h0,        2'd2, 32'h0000_3000, 1'b0};
        vt[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'h4000_001F, 2'd3, 32'h4000_0000, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h5000_0010, 32'h0,        32'h0,        2'd1, 32'h5000_0000, 1'b1};
        vt[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_6000, 32'h0000_7008, 32'h0000_8000, 2'd1, 32'h0000_6000, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_9020, 32'h0000_A000, 2'd2, 32'h0000_9020, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        32'hB000_0ABC, 2'd3, 32'hB000_0AA0, 1'b0};
        vt[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h7000_0020, 32'h0,        32'h0,        2'd1, 32'h7000_0020, 1'b0};

        star_exp[0] = 2'd1;
        star_exp[1] = 2'd1;
        star_exp[2] = 2'd1;
        star_exp[3] = 2'd1;
        star_exp[4] = 2'd2;
        star_exp[5] = 2'd1;

        // Reset
        do_reset();
        @(negedge clk);
        chk("rst_grant_id", 256'(grant_id), 256'd0);
        chk("rst_resp", 256'({bus.dc_resp, bus.ic_resp, bus.pf_resp}), 256'd0);
        chk("rst_dfp_rw", 256'({bus.dfp_read, bus.dfp_write}), 256'd0);
        chk("rst_dfp_addr", 256'(bus.dfp_addr), 256'd0);
        chk("rst_dfp_wdata", bus.dfp_wdata, 256'd0);

        // Table-driven single transactions
        for (int i = 0; i < 9; i++) begin
            wd = {8{32'hA500_0000 | 32'(i)}};
            rd = {8{32'h5A00_0000 | 32'(i)}};
            bus.dc_read  = vt[i].dc_rd;
            bus.dc_write = vt[i].dc_wr;
            bus.ic_read  = vt[i].ic_rd;
            bus.pf_read  = vt[i].pf_rd;
            bus.dc_addr  = vt[i].dc_a;
            bus.ic_addr  = vt[i].ic_a;
            bus.pf_addr  = vt[i].pf_a;
            bus.dc_wdata = wd;
            tick();
            // Scramble requester inputs: latched transaction must not move.
            bus.dc_addr  = 32'hFFFF_FFFF;
            bus.ic_addr  = 32'hFFFF_FFFF;
            bus.pf_addr  = 32'hFFFF_FFFF;
            bus.dc_wdata = '1;
            @(negedge clk);
            chk($sformatf("v%0d_grant_id", i), 256'(grant_id), 256'(vt[i].exp_gid));
            chk($sformatf("v%0d_dfp_addr", i), 256'(bus.dfp_addr), 256'(vt[i].exp_addr));
            chk($sformatf("v%0d_dfp_read", i), 256'(bus.dfp_read), 256'(!vt[i].exp_wr));
            chk($sformatf("v%0d_dfp_write", i), 256'(bus.dfp_write), 256'(vt[i].exp_wr));
            if (vt[i].exp_wr) chk($sformatf("v%0d_dfp_wdata", i), bus.dfp_wdata, wd);
            chk($sformatf("v%0d_no_early_resp", i),
                256'({bus.dc_resp, bus.ic_resp, bus.pf_resp}), 256'd0);
            bus.dfp_rdata = rd;
            bus.dfp_resp  = 1'b1;
            #1;
            chk($sformatf("v%0d_resp", i), 256'({bus.dc_resp, bus.ic_resp, bus.pf_resp}),
                256'(resp_onehot(vt[i].exp_gid)));
            chk($sformatf("v%0d_rdata", i), owner_rdata(vt[i].exp_gid), rd);
            tick();
            idle_inputs();
            @(negedge clk);
            chk($sformatf("v%0d_grant_cleared", i), 256'(grant_id), 256'd0);
            tick();
        end

        // Back-to-back: dc write then ic read with one bubble cycle between.
        do_reset();
        bus.dc_write = 1'b1;
        bus.dc_addr  = 32'h0000_2000;
        bus.dc_wdata = {8{32'hDEAD_BEEF}};
        bus.ic_read  = 1'b1;
        bus.ic_addr  = 32'h0000_3000;
        tick();
        @(negedge clk);
        chk("b2b_dc_grant", 256'(grant_id), 256'd1);
        chk("b2b_dc_write", 256'(bus.dfp_write), 256'd1);
        chk("b2b_dc_wdata", bus.dfp_wdata, {8{32'hDEAD_BEEF}});
        bus.dfp_resp = 1'b1;
        #1;
        chk("b2b_dc_resp", 256'(bus.dc_resp), 256'd1);
        tick();
        bus.dfp_resp = 1'b0;
        bus.dc_write = 1'b0;
        @(negedge clk);
        chk("b2b_bubble", 256'({grant_id, bus.dfp_read, bus.dfp_write}), 256'd0);
        tick();
        @(negedge clk);
        chk("b2b_ic_grant", 256'(grant_id), 256'd2);
        chk("b2b_ic_addr", 256'(bus.dfp_addr), 256'h0000_3000);
        bus.dfp_rdata = {8{32'h1234_5678}};
        bus.dfp_resp  = 1'b1;
        #1;
        chk("b2b_ic_resp", 256'({bus.dc_resp, bus.ic_resp, bus.pf_resp}), 256'(3'b010));
        chk("b2b_ic_rdata", bus.ic_rdata, {8{32'h1234_5678}});
        tick();
        idle_inputs();

        // Starvation: continuous dcache pressure, icache must win the 5th round.
        do_reset();
        bus.dc_read = 1'b1;
        bus.dc_addr = 32'h0000_1100;
        bus.ic_read = 1'b1;
        bus.ic_addr = 32'h0000_2200;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("starve_round%0d_grant", k), 256'(grant_id), 256'(star_exp[k]));
            bus.dfp_resp = 1'b1;
            #1;
            chk($sformatf("starve_round%0d_resp", k),
                256'({bus.dc_resp, bus.ic_resp, bus.pf_resp}), 256'(resp_onehot(star_exp[k])));
            tick();
            bus.dfp_resp = 1'b0;
            if (star_exp[k] == 2'd2) bus.ic_read = 1'b0;
            @(negedge clk);
            chk($sformatf("starve_round%0d_bubble", k), 256'(grant_id), 256'd0);
        end
        idle_inputs();
        tick();

        // Prefetch pulse while BUSY on dc, then dropped: never granted.
        bus.dc_read = 1'b1;
        bus.dc_addr = 32'h0000_4400;
        tick();
        bus.pf_read = 1'b1;
        bus.pf_addr = 32'h0000_8800;
        tick();
        bus.pf_read = 1'b0;
        @(negedge clk);
        chk("pfdrop_dc_owner", 256'(grant_id), 256'd1);
        tick();
        bus.dfp_resp = 1'b1;
        #1;
        chk("pfdrop_dc_resp", 256'({bus.dc_resp, bus.ic_resp, bus.pf_resp}), 256'(3'b100));
        tick();
        bus.dfp_resp = 1'b0;
        bus.dc_read  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("pfdrop_idle%0d", k), 256'({grant_id, bus.pf_resp, bus.dfp_read}), 256'd0);
            tick();
        end

        // Mid-flight reset while BUSY on ic; late adapter resp must be ignored.
        bus.ic_read = 1'b1;
        bus.ic_addr = 32'h0000_5500;
        tick();
        @(negedge clk);
        chk("midrst_ic_grant", 256'(grant_id), 256'd2);
        tick();
        rst = 1'b1;
        bus.ic_read = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_grant_cleared", 256'(grant_id), 256'd0);
        bus.dfp_resp = 1'b1;
        #1;
        chk("midrst_no_resp", 256'({bus.dc_resp, bus.ic_resp, bus.pf_resp}), 256'd0);
        chk("midrst_dfp_idle", 256'({bus.dfp_read, bus.dfp_write}), 256'd0);
        tick();
        bus.dfp_resp = 1'b0;
        @(negedge clk);
        chk("midrst_still_idle", 256'(grant_id), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
